sram_port_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 13 +
 rtl/sram_port_arbiter_if.sv | 18 +
 rtl/rr_picker.sv | 27 ++
 rtl/sram_port_arbiter.sv | 75 +++++++
 tb/tb_sram_port_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared widths and index helpers for the round-robin arbiters.
package arb_pkg;
    localparam int MAX_REQ = 8;
    localparam int ID_WIDTH = $clog2(MAX_REQ);

    function automatic logic [ID_WIDTH-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [ID_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++)
            if (oh[i]) idx = idx | ID_WIDTH'(i);
        return idx;
    endfunction
endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester-side bus of the shared SRAM port.
interface sram_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] lock;
    logic [NUM_REQ-1:0] we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, lock, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave (input req, lock, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first request at or after ptr.
module rr_picker
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  pick,
    output logic [ID_WIDTH-1:0] idx
);
    always_comb begin
        int best;
        int d;
        best = NUM_REQ;
        d = 0;
        pick = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i - int'(ptr) + NUM_REQ) % NUM_REQ;
            if (req[i] && d < best) begin
                best = d;
                pick = NUM_REQ'(1) << i;
            end
        end
        idx = onehot_to_idx(MAX_REQ'(pick));
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of one single-port SRAM with burst locking
// and tagged one-cycle read return.
module sram_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port_arbiter_if.slave    bus,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    logic [ID_WIDTH-1:0] prio_ptr, owner, rd_id, pick_idx, gid;
    logic [NUM_REQ-1:0]  pick;
    logic                locked, rd_pend, hold, lock_g;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (bus.req),
        .ptr (prio_ptr),
        .pick(pick),
        .idx (pick_idx)
    );

    // The owner keeps the port only while it still asserts both req and lock.
    always_comb begin
        hold = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (owner == ID_WIDTH'(i)) hold = locked & bus.req[i] & bus.lock[i];
        gid = hold ? owner : pick_idx;
        bus.gnt = '0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_din = '0;
        lock_g = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (rst_n && (hold || |pick) && gid == ID_WIDTH'(i)) begin
                bus.gnt[i] = 1'b1;
                mem_we = bus.we[i];
                mem_addr = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_din = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
                lock_g = bus.lock[i];
            end
        mem_cs = |bus.gnt;
        bus.rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (rd_pend && rd_id == ID_WIDTH'(i)) bus.rvalid[i] = 1'b1;
        bus.rdata = rd_pend ? mem_dout : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ptr <= '0;
            owner <= '0;
            locked <= 1'b0;
            rd_pend <= 1'b0;
            rd_id <= '0;
        end else begin
            rd_pend <= mem_cs & ~mem_we;
            rd_id <= gid;
            if (mem_cs && lock_g) begin
                locked <= 1'b1;
                owner <= gid;
            end else begin
                locked <= 1'b0;
                if (mem_cs) prio_ptr <= (gid == ID_WIDTH'(NUM_REQ-1)) ? '0 : gid + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of arbitration, locking, read return and reset.
module tb_sram_port_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic [DW-1:0] mem [16];
    int total = 0;
    int bad = 0;

    sram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .mem_cs  (mem_cs),
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_din (mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM with one-cycle read latency
    always @(posedge clk)
        if (mem_cs) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else mem_dout <= mem[mem_addr];
        end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [NR-1:0] r, input logic [NR-1:0] l, input logic [NR-1:0] w);
        bus.req = r;
        bus.lock = l;
        bus.we = w;
    endtask

    initial begin
        logic [NR-1:0] rr_exp [6];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);
        mem[5] = 8'hA7;
        mem_dout = '0;
        bus.addr = '0;
        bus.wdata = '0;
        set_req(3'b111, 3'b000, 3'b000);
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_cs", 32'(mem_cs), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_rdata", 32'(bus.rdata), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            check($sformatf("rr_gnt%0d", k), 32'(bus.gnt), 32'(rr_exp[k]));
            if (k > 0) check($sformatf("rr_rvalid%0d", k), 32'(bus.rvalid), 32'(rr_exp[k-1]));
        end

        @(negedge clk);
        set_req(3'b010, 3'b000, 3'b000);
        bus.addr[AW +: AW] = 4'd5;
        #1;
        check("rd_gnt", 32'(bus.gnt), 32'h2);
        check("rd_mem_addr", 32'(mem_addr), 32'h5);
        check("rd_mem_we", 32'(mem_we), 32'h0);
        check("rr_last_rvalid", 32'(bus.rvalid), 32'h4);

        @(negedge clk);
        set_req(3'b100, 3'b000, 3'b100);
        bus.addr[2*AW +: AW] = 4'd15;
        bus.wdata[2*DW +: DW] = 8'hFF;
        #1;
        check("rd_rvalid", 32'(bus.rvalid), 32'h2);
        check("rd_rdata", 32'(bus.rdata), 32'hA7);
        check("wr_gnt", 32'(bus.gnt), 32'h4);
        check("wr_cs", 32'(mem_cs), 32'h1);
        check("wr_we", 32'(mem_we), 32'h1);
        check("wr_addr", 32'(mem_addr), 32'hF);
        check("wr_din", 32'(mem_din), 32'hFF);

        @(negedge clk);
        set_req(3'b000, 3'b000, 3'b000);
        #1;
        check("wr_no_rvalid", 32'(bus.rvalid), 32'h0);
        check("idle_cs", 32'(mem_cs), 32'h0);
        check("idle_gnt", 32'(bus.gnt), 32'h0);

        @(negedge clk);
        set_req(3'b101, 3'b001, 3'b000);
        bus.addr[0 +: AW] = 4'd2;
        #1;
        check("lk1_gnt", 32'(bus.gnt), 32'h1);
        check("lk1_addr", 32'(mem_addr), 32'h2);

        @(negedge clk);
        set_req(3'b101, 3'b001, 3'b001);
        bus.wdata[0 +: DW] = 8'h3C;
        #1;
        check("lk2_gnt", 32'(bus.gnt), 32'h1);
        check("lk2_we", 32'(mem_we), 32'h1);
        check("lk1_rvalid", 32'(bus.rvalid), 32'h1);
        check("lk1_rdata", 32'(bus.rdata), 32'h02);

        @(negedge clk);
        set_req(3'b101, 3'b001, 3'b000);
        #1;
        check("lk3_gnt", 32'(bus.gnt), 32'h1);
        check("lk2_no_rvalid", 32'(bus.rvalid), 32'h0);

        @(negedge clk);
        set_req(3'b100, 3'b000, 3'b000);
        #1;
        check("lk_rel_gnt", 32'(bus.gnt), 32'h4);
        check("lk3_rvalid", 32'(bus.rvalid), 32'h1);
        check("lk3_rdata", 32'(bus.rdata), 32'h3C);

        @(negedge clk);
        set_req(3'b000, 3'b000, 3'b000);
        #1;
        check("r2_rvalid", 32'(bus.rvalid), 32'h4);
        check("r2_rdata", 32'(bus.rdata), 32'hFF);

        @(negedge clk);
        set_req(3'b100, 3'b100, 3'b000);
        #1;
        check("lkr_gnt", 32'(bus.gnt), 32'h4);

        @(negedge clk);
        set_req(3'b110, 3'b100, 3'b000);
        #1;
        check("lkr_hold", 32'(bus.gnt), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rvalid", 32'(bus.rvalid), 32'h0);
        check("arst_gnt", 32'(bus.gnt), 32'h0);
        check("arst_cs", 32'(mem_cs), 32'h0);

        @(negedge clk);
        #1;
        check("arst_rvalid2", 32'(bus.rvalid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(3'b111, 3'b100, 3'b000);
        #1;
        check("post_rst_gnt", 32'(bus.gnt), 32'h1);
        check("post_rst_rvalid", 32'(bus.rvalid), 32'h0);

        @(negedge clk);
        set_req(3'b000, 3'b000, 3'b000);
        #1;
        check("post_rst_rd", 32'(bus.rvalid), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
